// File: rtl/floo_axis_vc_credit_arbiter_pkg.sv
// Shared types and constants for the AXIS request/response VC credit arbiter.
// The default credit depth also sizes the bridge's remote receive FIFOs.
package floo_axis_vc_credit_arbiter_pkg;

    typedef enum logic {
        VcReq = 1'b0,
        VcRsp = 1'b1
    } vc_sel_e;

    typedef enum logic {
        StArb  = 1'b0,
        StLock = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultNumCredits = 2;

    function automatic vc_sel_e other_vc(input vc_sel_e vc);
        return (vc == VcReq) ? VcRsp : VcReq;
    endfunction

endpackage

// File: rtl/floo_vc_credit_counter.sv
// Credit counter tracking free slots of one remote per-VC receive FIFO.
// Saturates at NumCredits on a surplus return and raises a sticky overflow flag.
module floo_vc_credit_counter
    import floo_axis_vc_credit_arbiter_pkg::*;
#(
    parameter int unsigned NumCredits = DefaultNumCredits,
    parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                consume_i,
    input  logic                return_i,
    output logic [CntWidth-1:0] count_o,
    output logic                avail_o,
    output logic                overflow_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

    logic [CntWidth-1:0] count_d, count_q;
    logic                ovf_d, ovf_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (consume_i && !return_i) begin
            count_d = count_q - 1'b1;
        end else if (return_i && !consume_i) begin
            if (count_q == MaxCnt) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= MaxCnt;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign avail_o    = (count_q != '0);
    assign overflow_o = ovf_q;

endmodule

// File: rtl/floo_axis_vc_credit_arbiter.sv
// Round-robin, credit-gated arbiter sharing one AXIS link between the request
// and response VCs; holds the grant locked while the link applies backpressure.
module floo_axis_vc_credit_arbiter
    import floo_axis_vc_credit_arbiter_pkg::*;
#(
    parameter int unsigned NumCredits   = DefaultNumCredits,
    parameter int unsigned CntWidth     = $clog2(NumCredits + 1),
    parameter bit          IgnoreAssert = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                sel_o,
    input  logic                credit_req_i,
    input  logic                credit_rsp_i,
    output logic [CntWidth-1:0] credits_req_o,
    output logic [CntWidth-1:0] credits_rsp_o,
    output logic                err_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

    arb_state_e state_d, state_q;
    vc_sel_e    grant, sel_q, ptr_d, ptr_q;
    logic       avail_req, avail_rsp, elig_req, elig_rsp;
    logic       ovf_req, ovf_rsp, hs;

    assign elig_req = req_valid_i & avail_req;
    assign elig_rsp = rsp_valid_i & avail_rsp;

    // Zero-latency grant in StArb; StLock replays the registered grant.
    always_comb begin
        grant = sel_q;
        if (state_q == StArb) begin
            if (elig_req && elig_rsp) begin
                grant = ptr_q;
            end else if (elig_req) begin
                grant = VcReq;
            end else if (elig_rsp) begin
                grant = VcRsp;
            end
        end
    end

    assign out_valid_o = (grant == VcReq) ? elig_req : elig_rsp;
    assign hs          = out_valid_o & out_ready_i;
    assign req_ready_o = hs & (grant == VcReq);
    assign rsp_ready_o = hs & (grant == VcRsp);
    assign sel_o       = grant;

    assign state_d = (out_valid_o && !out_ready_i) ? StLock : StArb;
    assign ptr_d   = hs ? other_vc(grant) : ptr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StArb;
            sel_q   <= VcReq;
            ptr_q   <= VcReq;
        end else begin
            state_q <= state_d;
            sel_q   <= grant;
            ptr_q   <= ptr_d;
        end
    end

    floo_vc_credit_counter #(
        .NumCredits (NumCredits),
        .CntWidth   (CntWidth)
    ) i_cnt_req (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .consume_i  (req_ready_o),
        .return_i   (credit_req_i),
        .count_o    (credits_req_o),
        .avail_o    (avail_req),
        .overflow_o (ovf_req)
    );

    floo_vc_credit_counter #(
        .NumCredits (NumCredits),
        .CntWidth   (CntWidth)
    ) i_cnt_rsp (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .consume_i  (rsp_ready_o),
        .return_i   (credit_rsp_i),
        .count_o    (credits_rsp_o),
        .avail_o    (avail_rsp),
        .overflow_o (ovf_rsp)
    );

    assign err_o = ovf_req | ovf_rsp;

    // A valid drop while locked also trips the stability check.
    assert property (@(posedge clk_i) disable iff (!rst_ni || IgnoreAssert)
        out_valid_o && !out_ready_i |=> $stable(sel_o) && out_valid_o);
    assert property (@(posedge clk_i) disable iff (!rst_ni || IgnoreAssert)
        (credits_req_o <= MaxCnt) && (credits_rsp_o <= MaxCnt));
    assert property (@(posedge clk_i) disable iff (!rst_ni || IgnoreAssert)
        (!req_ready_o || credits_req_o != '0) && (!rsp_ready_o || credits_rsp_o != '0));

endmodule

// File: doc/floo_axis_vc_credit_arbiter.md
Name: floo_axis_vc_credit_arbiter

Overview:
- Control block that shares one outgoing AXIS link between the request and response flit virtual channels (VCs).
- Round-robin arbitration across VCs; a VC is eligible only if the remote receive FIFO for it has credit.
- Per-VC credit counters track free slots in the remote per-VC FIFOs; credit-return pulses from the remote side refill them.
- Drives the select of an external data mux and the valid/ready handshakes between the NoC flit ports and the AXIS output. Sits in front of the NoC-to-AXIS bridge.

Parameters:
- NumCredits, 2, depth of each remote per-VC receive FIFO; reset value of each credit counter (must be >= 1).
- CntWidth, $clog2(NumCredits+1), width of the credit counters (derived; do not override).
- IgnoreAssert, 1'b0, when 1 the internal assertions are disabled.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- req_valid_i  in  1  request VC has a flit.
- req_ready_o  out  1  request flit accepted.
- rsp_valid_i  in  1  response VC has a flit.
- rsp_ready_o  out  1  response flit accepted.
- out_valid_o  out  1  AXIS tvalid.
- out_ready_i  in  1  AXIS tready.
- sel_o  out  1  VC currently driving the mux and AXIS header; 0 = request, 1 = response.
- credit_req_i  in  1  one-cycle pulse: remote freed one request slot.
- credit_rsp_i  in  1  one-cycle pulse: remote freed one response slot.
- credits_req_o  out  CntWidth  current request credit count.
- credits_rsp_o  out  CntWidth  current response credit count.
- err_o  out  1  sticky credit-overflow flag.

Behaviour:
- Reset (synchronous, rst_ni=0 at a rising edge):
  - credits_*_o = NumCredits; err_o = 0.
  - Lock cleared; round-robin pointer = request VC.
  - Resulting outputs: sel_o = 0, out_valid_o = 0, req_ready_o = rsp_ready_o = 0.
- Reset mid-transfer discards the lock and any in-flight credit state.
- Eligibility: elig_X = X_valid_i & (credits_X != 0).
- State machine with two states:
  - ARB: grant is combinational, zero latency.
    - If only one VC is eligible, grant that VC.
    - If both are eligible, grant the VC named by the pointer.
    - If neither is eligible, sel_o keeps its registered value and out_valid_o = 0.
  - LOCK: entered when out_valid_o=1 and out_ready_i=0.
    - sel_o is frozen to the registered grant.
    - out_valid_o = 1 and stays 1 until the handshake completes.
    - Returns to ARB on the cycle after out_ready_i=1.
- Outputs:
  - out_valid_o = elig of the granted VC.
  - X_ready_o = out_ready_i & (sel_o == X) & out_valid_o; the ungranted VC always sees ready = 0.
- Pointer: on each handshake of VC X, the pointer moves to the other VC. This gives strict alternation under contention.
- AXIS stability: while in LOCK, sel_o must not change. The source must hold its valid; a valid drop while locked is a protocol violation and fires an assertion.
- Credits, per VC, each cycle:
  - Decrement by 1 on a handshake of that VC.
  - Increment by 1 on its credit_*_i pulse.
  - Both in the same cycle: count unchanged.
- A credit arriving while a VC sits at 0 makes it eligible in the next cycle, not the same cycle.
- Overflow: if an increment would exceed NumCredits, the count saturates at NumCredits and err_o is set. err_o clears only on reset.
- Underflow cannot occur because eligibility requires credit != 0; an assertion checks this.
- Assertions (enabled when IgnoreAssert = 0):
  - out_valid_o & !out_ready_i |=> $stable(sel_o) && out_valid_o.
  - Each credit count <= NumCredits.

Decomposition:
- Shared package (floo_axi_flit_pkg or the link package):
  - the vc_sel_e enum {VcReq=0, VcRsp=1};
  - the default credit depth constant, also used by the bridge's receive stream_fifo DEPTH.
- One sub-module, floo_vc_credit_counter, instantiated twice: parameters NumCredits; ports consume_i, return_i, count_o, avail_o, overflow_o.
- Arbitration and lock logic stay in the top level.

Test Plan:
- Reset with both VCs valid and credits = 2, out_ready_i = 1:
  - grants in order REQ, RSP, REQ, RSP;
  - after 4 cycles both credit counts = 0 and out_valid_o = 0.
- Only rsp_valid_i = 1, out_ready_i = 1, no credit returns:
  - 2 response handshakes, then out_valid_o = 0 and credits_rsp_o = 0;
  - a credit_rsp_i pulse brings out_valid_o = 1 on the following cycle.
- Backpressure: out_ready_i = 0 for 5 cycles with sel_o = REQ, then rsp_valid_i rises:
  - sel_o stays 0 and out_valid_o stays 1 for all 5 cycles;
  - the response is granted only after the request handshake.
- Simultaneous handshake and credit_req_i with count = 1 → count stays 1, no err_o.
- Credit pulse while count = NumCredits → count stays 2 and err_o = 1 until reset; reset then gives err_o = 0 and counts = 2.
- Reset asserted while in LOCK → sel_o = 0 and out_valid_o = 0 the next cycle; credits restored to 2.
